reg_scoreboard: RTL and testbench

- Tracks register-file destinations written by in-flight instructions, from decode/issue until writeback reaches the register file.
- Drives the read side's decode stall: a source register is busy while any older instruction still owes it a write.
- Cleared by writebacks on the register file's write port.
- Sits beside the register file in the decode stage; the same-cycle writeback bypass matches the register file's write-priority read.

---
 rtl/reg_scoreboard_if.sv | 32 +++
 rtl/reg_scoreboard.sv | 92 +++++++++
 tb/tb_reg_scoreboard.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle between the decode stage and the
// register scoreboard.
//   master : decode side, drives issue request, source addresses,
//            writeback and flush; observes busy/stall/pending/err
//   slave  : scoreboard side, the mirror image
interface reg_scoreboard_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  issue_valid;
    logic                  issue_we;
    logic [ADDR_WIDTH-1:0] issue_wa;
    logic [ADDR_WIDTH-1:0] ra0;
    logic [ADDR_WIDTH-1:0] ra1;
    logic                  wb_we;
    logic [ADDR_WIDTH-1:0] wb_wa;
    logic                  flush;
    logic                  busy0;
    logic                  busy1;
    logic                  stall;
    logic                  pending;
    logic                  err;

    modport master (
        output issue_valid, issue_we, issue_wa, ra0, ra1, wb_we, wb_wa, flush,
        input  busy0, busy1, stall, pending, err
    );

    modport slave (
        input  issue_valid, issue_we, issue_wa, ra0, ra1, wb_we, wb_wa, flush,
        output busy0, busy1, stall, pending, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one saturating pending-write counter per architectural
// register. Issue increments the destination's counter, writeback decrements
// it. Sources are busy while their count, after this cycle's writeback, is
// nonzero.
//   clk, rst : clock, asynchronous active-high reset
//   sb       : reg_scoreboard_if slave (issue, sources, writeback, flush in;
//              busy0/busy1/stall combinational, pending/err registered out)
module reg_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 2
) (
    input  logic clk,
    input  logic rst,
    reg_scoreboard_if.slave sb
);
    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] R0  = '0;

    logic [NREG-1:0][CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [NREG-1:0]                nz_nxt;
    logic                           pending_q, err_q;

    // Counts seen at the two source ports and the issue destination
    logic [CNT_WIDTH-1:0] c0, c1, ci, cw;
    logic                 wb_hit0, wb_hit1, wb_hiti;
    logic                 busy0, busy1, sat, stall, fire;

    assign c0 = cnt[sb.ra0];
    assign c1 = cnt[sb.ra1];
    assign ci = cnt[sb.issue_wa];
    assign cw = cnt[sb.wb_wa];

    assign wb_hit0 = sb.wb_we && (sb.wb_wa == sb.ra0);
    assign wb_hit1 = sb.wb_we && (sb.wb_wa == sb.ra1);
    assign wb_hiti = sb.wb_we && (sb.wb_wa == sb.issue_wa);

    // Effective count is zero only if nothing is pending, or the one
    // remaining write retires this very cycle (write-priority bypass).
    assign busy0 = (sb.ra0 != R0) && (c0 != '0) && !((c0 == ONE) && wb_hit0);
    assign busy1 = (sb.ra1 != R0) && (c1 != '0) && !((c1 == ONE) && wb_hit1);

    // A same-cycle writeback to a full counter frees a slot for this issue.
    assign sat   = sb.issue_we && (sb.issue_wa != R0) && (ci == CMAX) && !wb_hiti;
    assign stall = sb.issue_valid && (sb.flush || busy0 || busy1 || sat);
    assign fire  = sb.issue_valid && !stall;

    // Register 0 is hardwired: never counted, never busy.
    assign cnt_nxt[0] = '0;
    assign nz_nxt[0]  = 1'b0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_reg
            localparam logic [ADDR_WIDTH-1:0] RA = ADDR_WIDTH'(r);
            logic inc, dec;
            assign inc = fire && sb.issue_we && (sb.issue_wa == RA);
            // No underflow: a stray writeback leaves the count at zero.
            assign dec = sb.wb_we && (sb.wb_wa == RA) && (cnt[r] != '0);
            always_comb begin
                cnt_nxt[r] = cnt[r];
                if (sb.flush)
                    cnt_nxt[r] = '0;
                else if (inc && !dec)
                    cnt_nxt[r] = cnt[r] + ONE;
                else if (dec && !inc)
                    cnt_nxt[r] = cnt[r] - ONE;
            end
            assign nz_nxt[r] = (cnt_nxt[r] != '0);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            pending_q <= |nz_nxt;
            if (sb.wb_we && (sb.wb_wa != R0) && (cw == '0) && !sb.flush)
                err_q <= 1'b1;
        end
    end

    assign sb.busy0   = busy0;
    assign sb.busy1   = busy1;
    assign sb.stall   = stall;
    assign sb.pending = pending_q;
    assign sb.err     = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed-vector bench for reg_scoreboard. Inputs change 1 time unit after
// a rising edge; outputs are sampled 2 units later, well before the next edge.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reg_scoreboard_if #(.ADDR_WIDTH(5)) sb ();

    reg_scoreboard #(.ADDR_WIDTH(5), .CNT_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic iwe, input logic [4:0] iwa,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic wwe, input logic [4:0] wwa, input logic fl);
        sb.issue_valid = iv;
        sb.issue_we    = iwe;
        sb.issue_wa    = iwa;
        sb.ra0         = a0;
        sb.ra1         = a1;
        sb.wb_we       = wwe;
        sb.wb_wa       = wwa;
        sb.flush       = fl;
        #2;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset state; stall still responds to issue_valid && flush
        chk("rst_busy0", 32'(sb.busy0), 0);
        chk("rst_busy1", 32'(sb.busy1), 0);
        chk("rst_stall", 32'(sb.stall), 0);
        chk("rst_pending", 32'(sb.pending), 0);
        chk("rst_err", 32'(sb.err), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_stall_flush", 32'(sb.stall), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3 rst = 1'b0;
        cyc();

        // Issue r5, then it is busy next cycle
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        chk("t1_fire_stall", 32'(sb.stall), 0);
        cyc();
        drive(1, 0, 0, 5, 0, 0, 0, 0);
        chk("t1_busy0", 32'(sb.busy0), 1);
        chk("t1_stall", 32'(sb.stall), 1);
        chk("t1_pending", 32'(sb.pending), 1);
        cyc();

        // Writeback bypass releases ra1=5 in the same cycle
        drive(1, 0, 0, 0, 5, 1, 5, 0);
        chk("t2_busy1_bypass", 32'(sb.busy1), 0);
        chk("t2_stall", 32'(sb.stall), 0);
        cyc();
        drive(0, 0, 0, 0, 5, 0, 0, 0);
        chk("t2_busy1_after", 32'(sb.busy1), 0);
        chk("t2_pending", 32'(sb.pending), 0);

        // Fill r7 to CMAX
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(1, 1, 7, 0, 0, 0, 0, 0);
            chk($sformatf("t3_fill%0d", i), 32'(sb.stall), 0);
        end
        cyc();
        drive(1, 1, 7, 0, 0, 0, 0, 0);
        chk("t3_sat_stall", 32'(sb.stall), 1);
        drive(1, 1, 7, 0, 0, 1, 7, 0);
        chk("t3_sat_wb_stall", 32'(sb.stall), 0);
        cyc();
        // Drain: count must still be 3, so three writebacks leave no error
        drive(0, 0, 0, 7, 0, 1, 7, 0);
        chk("t3_drain1_busy", 32'(sb.busy0), 1);
        cyc();
        drive(0, 0, 0, 7, 0, 1, 7, 0);
        chk("t3_drain2_busy", 32'(sb.busy0), 1);
        chk("t3_drain2_pend", 32'(sb.pending), 1);
        cyc();
        drive(0, 0, 0, 7, 0, 1, 7, 0);
        chk("t3_drain3_busy", 32'(sb.busy0), 0);
        cyc();
        drive(0, 0, 0, 7, 0, 0, 0, 0);
        chk("t3_pending", 32'(sb.pending), 0);
        chk("t3_err", 32'(sb.err), 0);
        cyc();

        // Register 0 ignored
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("t4_r0_stall", 32'(sb.stall), 0);
        cyc();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t4_r0_busy", 32'(sb.busy0), 0);
        chk("t4_r0_pending", 32'(sb.pending), 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_r0_err", 32'(sb.err), 0);
        cyc();

        // Flush: cnt[3]=2, cnt[9]=1
        drive(1, 1, 3, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 1, 3, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 1, 9, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 1, 4, 0, 0, 0, 0, 1);
        chk("t5_flush_stall", 32'(sb.stall), 1);
        cyc();
        drive(0, 0, 0, 3, 9, 0, 0, 0);
        chk("t5_busy0", 32'(sb.busy0), 0);
        chk("t5_busy1", 32'(sb.busy1), 0);
        chk("t5_pending", 32'(sb.pending), 0);
        drive(0, 0, 0, 4, 0, 0, 0, 0);
        chk("t5_nofire_r4", 32'(sb.busy0), 0);
        cyc();

        // Stray writeback sets sticky err; async reset clears it
        drive(0, 0, 0, 0, 0, 1, 12, 0);
        chk("t6_err_pre", 32'(sb.err), 0);
        cyc();
        drive(0, 0, 0, 12, 0, 0, 0, 0);
        chk("t6_err_set", 32'(sb.err), 1);
        chk("t6_busy_r12", 32'(sb.busy0), 0);
        cyc();
        drive(0, 0, 0, 12, 0, 0, 0, 0);
        chk("t6_err_held", 32'(sb.err), 1);
        rst = 1'b1;
        #1;
        chk("t6_err_async", 32'(sb.err), 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
